// File: rtl/axi4_lite_read_master.sv
// ---------------------------------------------------------------------------
// axi4_lite_read_master
//
// AXI4-Lite read-channel master. Turns single-word load requests from the
// core's memory stage into AR/R transactions, one transaction outstanding at
// a time. A programmable timeout returns an error response when the slave
// never completes the transaction.
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-low reset
//   req_valid/addr   core load request; accepted when req_ready is high
//   req_ready        master idle (a request present this cycle is accepted)
//   resp_valid       one-cycle pulse qualifying resp_data / resp_err
//   resp_data        last returned read data (held between responses)
//   resp_err         SLVERR/DECERR from the slave, or timeout
//   busy             transaction in flight (inverse of req_ready)
//   M_AXI_AR*        read address channel
//   M_AXI_R*         read data channel
// ---------------------------------------------------------------------------
module axi4_lite_read_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256   // 0 disables the timeout
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_e;

  // Counter is wide enough to hold TIMEOUT_CYCLES itself so it can saturate.
  localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                  tmo_hit;

  // Only RRESP[1] distinguishes error from OKAY/EXOKAY.
  logic unused_rresp0;
  assign unused_rresp0 = M_AXI_RRESP[0];

  // Saturated counter stays at or above the last cycle, so a late AR
  // handshake that lands on the final cycle still times out in ST_DATA.
  assign tmo_hit = (TIMEOUT_CYCLES > 0) && (tmo_cnt_q >= TMO_LAST);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // it unassigned and infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    err_d     = err_q;
    tmo_cnt_d = tmo_cnt_q;

    case (state_q)
      ST_IDLE: begin
        // A stray RVALID here is a late beat from a timed-out read; RREADY is
        // high so it is consumed, and nothing is captured.
        if (req_valid) begin
          addr_d    = req_addr;
          tmo_cnt_d = '0;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (tmo_cnt_q != TMO_MAX) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        // The handshake is checked first so it wins over a same-cycle timeout.
        if (M_AXI_ARREADY) begin
          state_d = ST_DATA;
        end else if (tmo_hit) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_DATA: begin
        if (tmo_cnt_q != TMO_MAX) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (M_AXI_RVALID) begin
          data_d  = M_AXI_RDATA;
          err_d   = M_AXI_RRESP[1];
          state_d = ST_RESP;
        end else if (tmo_hit) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      err_q     <= err_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Moore outputs decoded from the state register; the async reset forces
  // ST_IDLE, which drops ARVALID in the same cycle.
  assign req_ready     = (state_q == ST_IDLE);
  assign busy          = ~req_ready;
  assign M_AXI_ARVALID = (state_q == ST_ADDR);
  assign M_AXI_ARADDR  = M_AXI_ARVALID ? addr_q : '0;
  assign M_AXI_RREADY  = (state_q == ST_IDLE) || (state_q == ST_DATA);
  assign resp_valid    = (state_q == ST_RESP);
  assign resp_data     = data_q;
  assign resp_err      = resp_valid & err_q;

endmodule

// File: tb/tb_axi4_lite_read_master.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_read_master
//
// Self-checking bench for axi4_lite_read_master (TIMEOUT_CYCLES = 16).
// A cycle-stepped slave driver answers each read with a chosen AR delay and
// R delay; a small reference model predicts response cycle, data and error
// from those delays using the timeout rule directly.
// ---------------------------------------------------------------------------
module tb_axi4_lite_read_master;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic          req_ready;
  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic          resp_err;
  logic          busy;
  logic [AW-1:0] M_AXI_ARADDR;
  logic          M_AXI_ARVALID;
  logic          M_AXI_ARREADY;
  logic [DW-1:0] M_AXI_RDATA;
  logic [1:0]    M_AXI_RRESP;
  logic          M_AXI_RVALID;
  logic          M_AXI_RREADY;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  axi4_lite_read_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_err     (resp_err),
    .busy         (busy),
    .M_AXI_ARADDR (M_AXI_ARADDR),
    .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA  (M_AXI_RDATA),
    .M_AXI_RRESP  (M_AXI_RRESP),
    .M_AXI_RVALID (M_AXI_RVALID),
    .M_AXI_RREADY (M_AXI_RREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // What one read looked like from the outside.
  typedef struct {
    logic          acc_ok;     // req_ready when the request was presented
    int            acc_cyc;    // cycle stamp of acceptance
    int            resp_k;     // cycles from accept to resp_valid (-1 = none)
    int            pulses;     // resp_valid pulses seen
    logic [DW-1:0] data;
    logic          err;
    int            addr_err;   // ARADDR wrong while valid, or nonzero while not
    int            busy_err;   // busy/req_ready wrong while in flight
    logic          idle_after; // req_ready after the response
    logic [DW-1:0] data_after; // resp_data held after the response
  } obs_t;

  typedef struct {
    int            k;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  // Reference: the R handshake must land no later than the last counted
  // cycle (cycle TMO after accept); otherwise the response is a timeout one
  // cycle after that. r_dly < 0 means the slave never answers.
  function automatic exp_t model(input int ar_dly, input int r_dly,
                                 input logic [DW-1:0] rdata, input logic [1:0] rresp);
    exp_t e;
    bit   ok;
    ok = (r_dly >= 0) && (ar_dly + r_dly + 2 <= TMO);
    e.k    = ok ? ar_dly + r_dly + 3 : TMO + 1;
    e.data = ok ? rdata : '0;
    e.err  = ok ? rresp[1] : 1'b1;
    return e;
  endfunction

  // Issue one read and play the slave. Called right after a falling edge;
  // returns right after a falling edge with the master back in idle.
  task automatic do_read(input logic [AW-1:0] addr, input int ar_dly, input int r_dly,
                         input logic [DW-1:0] rdata, input logic [1:0] rresp,
                         input logic junk_req, output obs_t o);
    int   ar_seen;
    int   ar_k;
    logic ar_done;
    logic r_done;
    logic r_hs;
    o.acc_ok     = req_ready;
    o.acc_cyc    = cyc;
    o.resp_k     = -1;
    o.pulses     = 0;
    o.data       = '0;
    o.err        = 1'b0;
    o.addr_err   = 0;
    o.busy_err   = 0;
    o.idle_after = 1'b0;
    o.data_after = '0;
    ar_seen = 0;
    ar_k    = 0;
    ar_done = 1'b0;
    r_done  = 1'b0;
    r_hs    = 1'b0;
    req_valid = 1'b1;
    req_addr  = addr;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      // A busy master must ignore a competing request held by the core.
      if (k == 1) begin
        if (junk_req) req_addr = ~addr;
        else          req_valid = 1'b0;
      end
      if (M_AXI_ARREADY) begin
        M_AXI_ARREADY = 1'b0;
        ar_done       = 1'b1;
      end
      if (M_AXI_RVALID && r_hs) begin
        M_AXI_RVALID = 1'b0;
        r_done       = 1'b1;
      end
      if (resp_valid) begin
        o.pulses++;
        if (o.resp_k < 0) begin
          o.resp_k = k;
          o.data   = resp_data;
          o.err    = resp_err;
        end
        req_valid = 1'b0;
      end
      if (o.resp_k < 0 || k == o.resp_k) begin
        if (!busy || req_ready) o.busy_err++;
      end
      if (M_AXI_ARVALID) begin
        if (M_AXI_ARADDR !== addr) o.addr_err++;
      end else if (M_AXI_ARADDR !== '0) begin
        o.addr_err++;
      end
      if (!ar_done && M_AXI_ARVALID) begin
        if (ar_seen == ar_dly) begin
          M_AXI_ARREADY = 1'b1;
          ar_k          = k;
        end
        ar_seen++;
      end
      if (ar_done && !r_done && r_dly >= 0 && k >= ar_k + 1 + r_dly) begin
        if (!M_AXI_RVALID) begin
          M_AXI_RVALID = 1'b1;
          M_AXI_RDATA  = rdata;
          M_AXI_RRESP  = rresp;
        end
        r_hs = M_AXI_RREADY;
      end else if (!M_AXI_RVALID) begin
        M_AXI_RDATA = $urandom;
        M_AXI_RRESP = 2'($urandom);
      end
      if (o.resp_k > 0 && k > o.resp_k && (r_done || r_dly < 0 || !ar_done)) begin
        o.idle_after = req_ready;
        o.data_after = resp_data;
        break;
      end
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({M_AXI_ARVALID, M_AXI_RREADY, req_ready, resp_valid, resp_err, busy} !== 6'b011000) begin
      failures++;
      $display("FAIL reset_ctrl: got arv/rrdy/rdy/rv/err/busy=%b expected 011000",
               {M_AXI_ARVALID, M_AXI_RREADY, req_ready, resp_valid, resp_err, busy});
    end
    checks++;
    if (M_AXI_ARADDR !== '0 || resp_data !== '0) begin
      failures++;
      $display("FAIL reset_data: got araddr=%h resp_data=%h expected 0/0", M_AXI_ARADDR, resp_data);
    end
  endtask

  task automatic test_basic;
    obs_t o;
    exp_t e;
    e = model(0, 0, 32'hDEAD_BEEF, 2'b00);
    do_read(32'h0000_1004, 0, 0, 32'hDEAD_BEEF, 2'b00, 1'b0, o);
    checks++;
    if (o.acc_ok !== 1'b1) begin failures++; $display("FAIL basic_accept: got req_ready=%b expected 1", o.acc_ok); end
    checks++;
    if (o.resp_k !== e.k || e.k !== 3) begin failures++; $display("FAIL basic_latency: got %0d expected 3", o.resp_k); end
    checks++;
    if (o.data !== e.data || o.err !== e.err) begin
      failures++; $display("FAIL basic_resp: got data=%h err=%b expected %h/%b", o.data, o.err, e.data, e.err);
    end
    checks++;
    if (o.data_after !== 32'hDEAD_BEEF || o.idle_after !== 1'b1) begin
      failures++; $display("FAIL basic_hold: got data=%h idle=%b expected deadbeef/1", o.data_after, o.idle_after);
    end
  endtask

  task automatic test_reset_mid;
    int rv_seen;
    int arv_seen;
    req_valid = 1'b1;
    req_addr  = 32'h0000_2220;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== 32'h0000_2220) begin
      failures++; $display("FAIL rstmid_pre: got arvalid=%b araddr=%h expected 1/00002220", M_AXI_ARVALID, M_AXI_ARADDR);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (M_AXI_ARVALID !== 1'b0 || M_AXI_ARADDR !== '0) begin
      failures++; $display("FAIL rstmid_arvalid: got arvalid=%b araddr=%h expected 0/0", M_AXI_ARVALID, M_AXI_ARADDR);
    end
    checks++;
    if ({M_AXI_RREADY, req_ready, resp_valid, resp_err, busy} !== 5'b11000 || resp_data !== '0) begin
      failures++; $display("FAIL rstmid_outputs: got rrdy/rdy/rv/err/busy=%b data=%h expected 11000/0",
                           {M_AXI_RREADY, req_ready, resp_valid, resp_err, busy}, resp_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rv_seen  = 0;
    arv_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid)    rv_seen++;
      if (M_AXI_ARVALID) arv_seen++;
    end
    checks++;
    if (rv_seen !== 0 || arv_seen !== 0) begin
      failures++; $display("FAIL rstmid_quiet: got resp_valid=%0d arvalid=%0d cycles expected 0/0", rv_seen, arv_seen);
    end
  endtask

  task automatic test_stall;
    obs_t o;
    exp_t e;
    e = model(5, 7, 32'hCAFE_0001, 2'b00);
    do_read(32'h4000_0010, 5, 7, 32'hCAFE_0001, 2'b00, 1'b1, o);
    checks++;
    if (o.addr_err !== 0) begin failures++; $display("FAIL stall_araddr: got %0d bad cycles expected 0", o.addr_err); end
    checks++;
    if (o.pulses !== 1) begin failures++; $display("FAIL stall_pulses: got %0d expected 1", o.pulses); end
    checks++;
    if (o.resp_k !== e.k || o.data !== e.data || o.err !== e.err) begin
      failures++; $display("FAIL stall_resp: got k=%0d data=%h err=%b expected %0d/%h/%b",
                           o.resp_k, o.data, o.err, e.k, e.data, e.err);
    end
    checks++;
    if (o.busy_err !== 0) begin failures++; $display("FAIL stall_busy: got %0d bad cycles expected 0", o.busy_err); end
  endtask

  task automatic test_error;
    obs_t o;
    exp_t e;
    e = model(1, 2, 32'h0000_1234, 2'b10);
    do_read(32'h0000_0100, 1, 2, 32'h0000_1234, 2'b10, 1'b0, o);
    checks++;
    if (o.err !== 1'b1 || o.data !== 32'h0000_1234 || o.resp_k !== e.k) begin
      failures++; $display("FAIL error_slverr: got k=%0d data=%h err=%b expected %0d/00001234/1", o.resp_k, o.data, o.err, e.k);
    end
    e = model(0, 1, 32'h0000_5678, 2'b01);
    do_read(32'h0000_0104, 0, 1, 32'h0000_5678, 2'b01, 1'b0, o);
    checks++;
    if (o.err !== e.err || o.data !== e.data) begin
      failures++; $display("FAIL error_exokay: got data=%h err=%b expected %h/%b", o.data, o.err, e.data, e.err);
    end
  endtask

  task automatic test_timeout;
    obs_t o;
    exp_t e;
    int   rv_seen;
    e = model(0, -1, 32'h0, 2'b00);
    do_read(32'h0000_0200, 0, -1, 32'h0, 2'b00, 1'b0, o);
    checks++;
    if (o.resp_k !== 17 || o.err !== 1'b1 || o.data !== '0 || o.resp_k !== e.k) begin
      failures++; $display("FAIL timeout_resp: got k=%0d data=%h err=%b expected 17/0/1", o.resp_k, o.data, o.err);
    end
    // Late beat arriving while idle must be consumed and dropped.
    M_AXI_RVALID = 1'b1;
    M_AXI_RDATA  = 32'hBAD0_BAD0;
    M_AXI_RRESP  = 2'b10;
    checks++;
    if (M_AXI_RREADY !== 1'b1) begin failures++; $display("FAIL timeout_stale_rready: got %b expected 1", M_AXI_RREADY); end
    @(negedge clk);
    M_AXI_RVALID = 1'b0;
    rv_seen = 0;
    repeat (2) begin
      if (resp_valid) rv_seen++;
      @(negedge clk);
    end
    checks++;
    if (rv_seen !== 0 || resp_data !== '0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL timeout_stale_drop: got pulses=%0d data=%h rdy=%b expected 0/0/1", rv_seen, resp_data, req_ready);
    end
    e = model(0, 0, 32'h5555_AAAA, 2'b00);
    do_read(32'h0000_0204, 0, 0, 32'h5555_AAAA, 2'b00, 1'b0, o);
    checks++;
    if (o.data !== e.data || o.err !== e.err || o.resp_k !== e.k) begin
      failures++; $display("FAIL timeout_next_read: got k=%0d data=%h err=%b expected %0d/%h/%b",
                           o.resp_k, o.data, o.err, e.k, e.data, e.err);
    end
  endtask

  task automatic test_race;
    obs_t o;
    exp_t e;
    // RVALID lands in the last counted cycle: the data wins.
    e = model(0, 14, 32'h0BAD_F00D, 2'b00);
    do_read(32'h0000_0300, 0, 14, 32'h0BAD_F00D, 2'b00, 1'b0, o);
    checks++;
    if (o.resp_k !== 17 || o.data !== 32'h0BAD_F00D || o.err !== 1'b0 || e.err !== 1'b0) begin
      failures++; $display("FAIL race_win: got k=%0d data=%h err=%b expected 17/0badf00d/0", o.resp_k, o.data, o.err);
    end
    // One cycle later: timeout, and the beat is swallowed afterwards.
    e = model(0, 15, 32'h7777_7777, 2'b00);
    do_read(32'h0000_0304, 0, 15, 32'h7777_7777, 2'b00, 1'b0, o);
    checks++;
    if (o.resp_k !== e.k || o.data !== e.data || o.err !== e.err || o.pulses !== 1) begin
      failures++; $display("FAIL race_lose: got k=%0d data=%h err=%b pulses=%0d expected %0d/%h/%b/1",
                           o.resp_k, o.data, o.err, o.pulses, e.k, e.data, e.err);
    end
    checks++;
    if (o.data_after !== '0 || o.idle_after !== 1'b1) begin
      failures++; $display("FAIL race_lose_drop: got data=%h idle=%b expected 0/1", o.data_after, o.idle_after);
    end
  endtask

  task automatic test_back_to_back;
    obs_t o1;
    obs_t o2;
    do_read(32'h0000_0400, 0, 0, 32'h1111_2222, 2'b00, 1'b0, o1);
    do_read(32'h0000_0404, 0, 0, 32'h3333_4444, 2'b00, 1'b0, o2);
    checks++;
    if (o2.acc_ok !== 1'b1 || (o2.acc_cyc - o1.acc_cyc) !== 4) begin
      failures++; $display("FAIL b2b_spacing: got ready=%b gap=%0d expected 1/4", o2.acc_ok, o2.acc_cyc - o1.acc_cyc);
    end
    checks++;
    if (o1.data !== 32'h1111_2222 || o2.data !== 32'h3333_4444) begin
      failures++; $display("FAIL b2b_data: got %h/%h expected 11112222/33334444", o1.data, o2.data);
    end
  endtask

  task automatic test_random;
    obs_t          o;
    exp_t          e;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [1:0]    rr;
    int            ar;
    int            r;
    logic          junk;
    for (int i = 0; i < 40; i++) begin
      a    = $urandom;
      d    = $urandom;
      rr   = 2'($urandom);
      ar   = int'($urandom_range(12, 0));
      r    = int'($urandom_range(18, 0));
      junk = 1'($urandom_range(1, 0));
      e = model(ar, r, d, rr);
      do_read(a, ar, r, d, rr, junk, o);
      checks++;
      if (o.resp_k !== e.k || o.data !== e.data || o.err !== e.err) begin
        failures++; $display("FAIL rand%0d_resp (ar=%0d r=%0d): got k=%0d data=%h err=%b expected %0d/%h/%b",
                             i, ar, r, o.resp_k, o.data, o.err, e.k, e.data, e.err);
      end
      checks++;
      if (o.pulses !== 1 || o.addr_err !== 0 || o.busy_err !== 0 || o.idle_after !== 1'b1) begin
        failures++; $display("FAIL rand%0d_proto: got pulses=%0d addr_err=%0d busy_err=%0d idle=%b expected 1/0/0/1",
                             i, o.pulses, o.addr_err, o.busy_err, o.idle_after);
      end
    end
  endtask

  initial begin
    rst           = 1'b0;
    req_valid     = 1'b0;
    req_addr      = '0;
    M_AXI_ARREADY = 1'b0;
    M_AXI_RVALID  = 1'b0;
    M_AXI_RDATA   = '0;
    M_AXI_RRESP   = 2'b00;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b1;
    @(negedge clk);
    test_basic;
    test_reset_mid;
    test_stall;
    test_error;
    test_timeout;
    test_race;
    test_back_to_back;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
